alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Control-side counterpart of the ALU result selector. Accepts an ALU opcode over a valid/ready handshake
//  and drives the one-hot select vector to the selector. Holds the select for the op's latency, then
//  captures the selected 2*BITS result into Z_HI/Z_LO and pulses done. Sits between the control unit and
//  the ALU datapath.
// PARAMETERS
//  BITS       32  datapath word width; selected result is 2*BITS
//  SIG_COUNT  13  number of one-hot select lines (ALU ops)
//  MUL_LAT    4   cycles select is held for MUL (>=1)
//  DIV_LAT    32  cycles select is held for DIV (>=1)
// PORTS
//  clk         in   1          clock, rising edge
//  clr         in   1          synchronous active-high reset
//  op_valid    in   1          opcode offered
//  op_ready    out  1          block can accept opcode
//  opcode      in   4          0 ADD,1 SUB,2 AND,3 OR,4 SHR,5 SHRA,6 SHL,7 ROR,8 ROL,9 MUL,10 DIV,11 NEG,12 NOT
//  ctrl_signal out  SIG_COUNT  one-hot select to result selector; all-zero when not executing
//  sel_result  in   2*BITS     result returned by the selector
//  z_hi        out  BITS       captured sel_result[2*BITS-1:BITS]
//  z_lo        out  BITS       captured sel_result[BITS-1:0]
//  done        out  1          one-cycle pulse: z_hi/z_lo updated
//  op_err      out  1          one-cycle pulse: illegal opcode rejected
// BEHAVIOUR
//  Reset: state IDLE, op_ready=1, ctrl_signal=0, z_hi=z_lo=0, done=0, op_err=0, counter=0.
//  FSM: IDLE -> EXEC -> DONE -> IDLE.
//  IDLE: op_ready=1. Transfer = op_valid&op_ready at clk edge.
//   - legal opcode (<SIG_COUNT): latch opcode, load cnt = MUL_LAT-1 / DIV_LAT-1 / 0; go EXEC.
//   - illegal opcode (>=SIG_COUNT): stay IDLE, op_err=1 next cycle; no select, Z unchanged.
//  EXEC: op_ready=0; ctrl_signal[opcode]=1, all other bits 0 (registered, glitch-free). cnt decrements.
//   - when cnt==0: capture sel_result into {z_hi,z_lo} at this edge; go DONE.
//   - select held 1 cycle (single-cycle ops), MUL_LAT cycles (MUL), DIV_LAT cycles (DIV).
//  DONE: done=1, ctrl_signal=0, op_ready=0; go IDLE next edge.
//  Latency: accept edge -> done high = L+1 cycles (L = held cycles). Throughput: 1 op per L+2 cycles.
//  op_valid while op_ready=0: ignored; no queueing, requester must hold op_valid.
//  opcode changes during EXEC: no effect (latched copy used).
//  clr mid-EXEC/DONE: at that edge abort, ctrl_signal=0, Z cleared, no done pulse.
//  clr with op_valid same edge: clr wins, opcode not accepted.
//  ctrl_signal never has >1 bit set; onehot check by assertion in sim.
//  cnt width = $clog2(max(MUL_LAT,DIV_LAT)) (min 1).
// CONFIGURATION
//  SEQ_FLAGS_EN defined: extra outputs z_zero (sel_result==0) and z_neg (sel_result[BITS-1]), both 1 bit,
//   captured on the same edge as Z; reset 0; held until next capture.
//  SEQ_FLAGS_EN undefined: ports and flag registers absent; all other behaviour identical.
// STRUCTURE
//  Shared package alu_op_pkg: opcode constants OP_ADD..OP_NOT, OP_COUNT=13, FSM state encoding
//   (ST_IDLE, ST_EXEC, ST_DONE), default MUL_LAT/DIV_LAT.
//  Sub-module alu_op_onehot_decoder: opcode -> SIG_COUNT one-hot (zero for illegal) plus legal flag;
//   combinational, registered by the sequencer.
// TESTING
//  1 clr asserted 2 cycles -> op_ready=1, ctrl_signal=0, z_hi=z_lo=0, done=0.
//  2 ADD (0), sel_result=64'h0000_0000_0000_0007 -> ctrl_signal=13'h0001 for 1 cycle; done on 2nd cycle
//    after accept; z_lo=7, z_hi=0.
//  3 MUL (9), MUL_LAT=4, sel_result=64'h0000_0001_8000_0000 -> ctrl_signal=13'h0200 for exactly 4 cycles;
//    z_hi=1, z_lo=32'h8000_0000; done 5 cycles after accept.
//  4 opcode 14 with op_valid -> op_err pulse 1 cycle, ctrl_signal stays 0, Z unchanged, op_ready stays 1.
//  5 DIV (10), clr on 3rd EXEC cycle -> ctrl_signal=0 next cycle, no done, z_hi=z_lo=0, op_ready=1.
//  6 back-to-back op_valid held (SUB then NOT): 2nd accepted only in IDLE after done; ctrl_signal
//    13'h0002 then 13'h1000, never overlapping. SEQ_FLAGS_EN: NOT result 0 -> z_zero=1, z_neg=0.

Source files
------------

// File: rtl/alu_op_pkg.sv
// Shared opcode constants, FSM state encoding and default latencies for the ALU op sequencer.
package alu_op_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  localparam int OP_COUNT    = 13;
  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_onehot_decoder.sv
// Combinational opcode to one-hot select decoder; illegal opcodes decode to all-zero with legal=0.
module alu_op_onehot_decoder #(
  parameter int SIG_COUNT = 13
) (
  input  logic [3:0]           opcode,
  output logic [SIG_COUNT-1:0] onehot,
  output logic                 legal
);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    onehot = '0;
    legal  = (int'(opcode) < SIG_COUNT);
    if (legal) onehot = SIG_COUNT'(1) << opcode;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU op: drives a registered one-hot select for the op latency, then captures the result.
// Optional SEQ_FLAGS_EN adds captured z_zero / z_neg result flags.
module alu_op_sequencer
  import alu_op_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int SIG_COUNT = OP_COUNT,
  parameter int MUL_LAT   = DEF_MUL_LAT,
  parameter int DIV_LAT   = DEF_DIV_LAT
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [3:0]           opcode,
  output logic [SIG_COUNT-1:0] ctrl_signal,
  input  logic [2*BITS-1:0]    sel_result,
  output logic [BITS-1:0]      z_hi,
  output logic [BITS-1:0]      z_lo,
  output logic                 done,
  output logic                 op_err
`ifdef SEQ_FLAGS_EN
  ,
  output logic                 z_zero,
  output logic                 z_neg
`endif
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_load;
  logic [SIG_COUNT-1:0]   dec_onehot;
  logic                   dec_legal;
  logic                   accept;

  alu_op_onehot_decoder #(.SIG_COUNT(SIG_COUNT)) u_dec (
    .opcode (opcode),
    .onehot (dec_onehot),
    .legal  (dec_legal)
  );

  assign accept = op_valid && op_ready;

  // Counter preload: cycles the select stays held, minus one.
  always_comb begin
    cnt_load = '0;
    if (opcode == OP_MUL)      cnt_load = CNT_W'(MUL_LAT - 1);
    else if (opcode == OP_DIV) cnt_load = CNT_W'(DIV_LAT - 1);
  end

  always_comb begin
    state_next = state;
    op_ready   = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid && dec_legal) state_next = ST_EXEC;
      end
      ST_EXEC: if (cnt == '0) state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ctrl_signal <= '0;
      z_hi        <= '0;
      z_lo        <= '0;
      op_err      <= 1'b0;
`ifdef SEQ_FLAGS_EN
      z_zero      <= 1'b0;
      z_neg       <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      op_err <= accept && !dec_legal;
      case (state)
        ST_IDLE: begin
          if (accept && dec_legal) begin
            ctrl_signal <= dec_onehot;
            cnt         <= cnt_load;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            ctrl_signal  <= '0;
            {z_hi, z_lo} <= sel_result;
`ifdef SEQ_FLAGS_EN
            z_zero       <= (sel_result == '0);
            z_neg        <= sel_result[BITS-1];
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ctrl_signal <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) assert ($onehot0(ctrl_signal));
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer; define SEQ_FLAGS_EN to also check result flags.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  opcode;
  logic [12:0] ctrl_signal;
  logic [63:0] sel_result;
  logic [31:0] z_hi, z_lo;
  logic        done, op_err;
`ifdef SEQ_FLAGS_EN
  logic        z_zero, z_neg;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.BITS(32), .SIG_COUNT(13), .MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk         (clk),
    .clr         (clr),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .opcode      (opcode),
    .ctrl_signal (ctrl_signal),
    .sel_result  (sel_result),
    .z_hi        (z_hi),
    .z_lo        (z_lo),
    .done        (done),
    .op_err      (op_err)
`ifdef SEQ_FLAGS_EN
    ,
    .z_zero      (z_zero),
    .z_neg       (z_neg)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one legal op, then verify select held exactly lat cycles, a done pulse and the captured result.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] res,
                        input int lat, input logic [12:0] exp_sel);
    opcode     = op;
    sel_result = res;
    op_valid   = 1'b1;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      check({tag, " sel"}, 64'(ctrl_signal), 64'(exp_sel));
      check({tag, " busy"}, {62'd0, op_ready, done}, 64'd0);
      tick();
    end
    check({tag, " done"}, {63'd0, done}, 64'd1);
    check({tag, " sel off"}, 64'(ctrl_signal), 64'd0);
    check({tag, " z"}, {z_hi, z_lo}, res);
    tick();
    check({tag, " idle"}, {62'd0, op_ready, done}, 64'd2);
  endtask

  initial begin
    clr        = 1'b1;
    op_valid   = 1'b0;
    opcode     = 4'd0;
    sel_result = '0;

    // Reset held two cycles.
    tick();
    tick();
    check("rst ready", {63'd0, op_ready}, 64'd1);
    check("rst sel", 64'(ctrl_signal), 64'd0);
    check("rst z", {z_hi, z_lo}, 64'd0);
    check("rst pulses", {62'd0, done, op_err}, 64'd0);
    clr = 1'b0;
    tick();

    // Single-cycle ADD, then 4-cycle MUL.
    run_op("add", 4'd0, 64'h0000_0000_0000_0007, 1, 13'h0001);
    run_op("mul", 4'd9, 64'h0000_0001_8000_0000, 4, 13'h0200);
`ifdef SEQ_FLAGS_EN
    check("mul flags", {62'd0, z_zero, z_neg}, 64'd1);
`endif

    // Illegal opcode: error pulse only.
    opcode   = 4'd14;
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    check("ill err", {63'd0, op_err}, 64'd1);
    check("ill sel", 64'(ctrl_signal), 64'd0);
    check("ill ready", {63'd0, op_ready}, 64'd1);
    check("ill z", {z_hi, z_lo}, 64'h0000_0001_8000_0000);
    tick();
    check("ill err pulse", {63'd0, op_err}, 64'd0);

    // DIV aborted by clr during its 3rd EXEC cycle.
    opcode     = 4'd10;
    sel_result = 64'h1234_5678_9abc_def0;
    op_valid   = 1'b1;
    tick();
    op_valid = 1'b0;
    check("div sel", 64'(ctrl_signal), 64'h0400);
    tick();
    tick();
    check("div sel 3", 64'(ctrl_signal), 64'h0400);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("abort sel", 64'(ctrl_signal), 64'd0);
    check("abort z", {z_hi, z_lo}, 64'd0);
    check("abort ready", {62'd0, op_ready, done}, 64'd2);
    begin
      logic saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        saw_done |= done;
      end
      check("abort no done", {63'd0, saw_done}, 64'd0);
    end

    // clr and op_valid on the same edge: clr wins.
    clr      = 1'b1;
    op_valid = 1'b1;
    opcode   = 4'd0;
    tick();
    clr      = 1'b0;
    op_valid = 1'b0;
    check("clr wins sel", 64'(ctrl_signal), 64'd0);
    check("clr wins ready", {63'd0, op_ready}, 64'd1);
    tick();
    check("clr wins idle", 64'(ctrl_signal), 64'd0);

    // Back-to-back SUB then NOT with op_valid held; opcode changes mid-EXEC.
    opcode     = 4'd1;
    sel_result = 64'h0000_0000_0000_0005;
    op_valid   = 1'b1;
    tick();
    opcode = 4'd12;
    check("sub sel", 64'(ctrl_signal), 64'h0002);
    check("sub ready", {63'd0, op_ready}, 64'd0);
    tick();
    check("sub done", {63'd0, done}, 64'd1);
    check("sub sel off", 64'(ctrl_signal), 64'd0);
    check("sub z", {z_hi, z_lo}, 64'd5);
    sel_result = 64'd0;
    tick();
    check("gap idle", {62'd0, op_ready, done}, 64'd2);
    check("gap sel", 64'(ctrl_signal), 64'd0);
    tick();
    op_valid = 1'b0;
    check("not sel", 64'(ctrl_signal), 64'h1000);
    tick();
    check("not done", {63'd0, done}, 64'd1);
    check("not z", {z_hi, z_lo}, 64'd0);
`ifdef SEQ_FLAGS_EN
    check("not flags", {62'd0, z_zero, z_neg}, 64'd2);
`endif
    tick();
    check("final idle", {62'd0, op_ready, done}, 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
